// File: rtl/cdc_hs_rx.sv
// Destination-side receiver for a toggle-based req/ack CDC handshake.
// Captures the sender's data when a request toggle arrives, hands it out with valid/ready, and returns an ack toggle.
module cdc_hs_rx #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   arst_master,
   input  logic                   clk_in_b,
   input  logic                   req_sync_i,
   input  logic [DATA_WIDTH-1:0]  data_i,
   output logic [DATA_WIDTH-1:0]  data_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   ack_o,
   output logic                   err_o,
   output logic [COUNT_WIDTH-1:0] count_o
);

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } stateT;

   stateT                  r_state;
   stateT                  w_stateNext;
   logic                   r_reqQ;
   logic [DATA_WIDTH-1:0]  r_data;
   logic                   r_valid;
   logic                   r_ack;
   logic                   r_err;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   w_toggle;
   logic                   w_capture;
   logic                   w_accept;
   logic                   w_violation;

   assign w_toggle = req_sync_i ^ r_reqQ;

   // A toggle seen in HOLD (even on the accepting edge) is dropped and flagged.
   always_comb begin
      w_stateNext = r_state;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      w_violation = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_toggle) begin
               w_capture   = 1'b1;
               w_stateNext = ST_HOLD;
            end
         end
         ST_HOLD: begin
            w_violation = w_toggle;
            if (ready_i) begin
               w_accept    = 1'b1;
               w_stateNext = ST_IDLE;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in_b or posedge arst_master) begin
      if (arst_master) begin
         r_state <= ST_IDLE;
         r_reqQ  <= 1'b0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_stateNext;
         r_reqQ  <= req_sync_i;
         if (w_capture) begin
            r_data  <= data_i;
            r_valid <= 1'b1;
         end
         if (w_accept) begin
            r_valid <= 1'b0;
            r_ack   <= ~r_ack;
            r_count <= r_count + COUNT_WIDTH'(1);
         end
         if (w_violation) begin
            r_err <= 1'b1;
         end
      end
   end

   assign data_o  = r_data;
   assign valid_o = r_valid;
   assign ack_o   = r_ack;
   assign err_o   = r_err;
   assign count_o = r_count;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Self-checking bench for cdc_hs_rx: table-driven cycle vectors plus hand-written corner sequences,
// with a data scoreboard filled when requests are driven and drained when valid_o rises.
module tb_cdc_hs_rx;

   logic        clock;
   logic        reset;
   logic        reqSync;
   logic [7:0]  dataIn;
   logic        ready;
   logic [7:0]  dataOut;
   logic        validOut;
   logic        ackOut;
   logic        errOut;
   logic [15:0] countOut;
   logic [7:0]  dataOutS;
   logic        validOutS;
   logic        ackOutS;
   logic        errOutS;
   logic [3:0]  countOutS;

   int checks = 0;
   int errors = 0;
   logic reqLevel = 1'b0;
   logic prevValid = 1'b0;
   logic [7:0] sbQueue[$];

   typedef struct {
      logic        tog;
      logic [7:0]  data;
      logic        rdy;
      logic        push;
      logic        expValid;
      logic [7:0]  expData;
      logic        expAck;
      logic [15:0] expCount;
      logic        expErr;
   } vecT;

   vecT vecs[9];

   cdc_hs_rx #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
      .arst_master(reset), .clk_in_b(clock), .req_sync_i(reqSync), .data_i(dataIn),
      .data_o(dataOut), .valid_o(validOut), .ready_i(ready), .ack_o(ackOut),
      .err_o(errOut), .count_o(countOut)
   );

   cdc_hs_rx #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dutSmall (
      .arst_master(reset), .clk_in_b(clock), .req_sync_i(reqSync), .data_i(dataIn),
      .data_o(dataOutS), .valid_o(validOutS), .ready_i(ready), .ack_o(ackOutS),
      .err_o(errOutS), .count_o(countOutS)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic compare(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then sample just after the next rising edge.
   task automatic applyStimulus(input logic tog, input logic [7:0] data, input logic rdy, input logic push);
      @(negedge clock);
      if (tog) reqLevel = ~reqLevel;
      reqSync = reqLevel;
      dataIn  = data;
      ready   = rdy;
      if (push) sbQueue.push_back(data);
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input logic expValid, input logic [7:0] expData, input logic expAck,
                              input logic [15:0] expCount, input logic expErr);
      compare("valid", int'(validOut), int'(expValid));
      compare("data", int'(dataOut), int'(expData));
      compare("ack", int'(ackOut), int'(expAck));
      compare("count", int'(countOut), int'(expCount));
      compare("err", int'(errOut), int'(expErr));
      compare("countSmall", int'(countOutS), int'(expCount[3:0]));
      compare("ackSmall", int'(ackOutS), int'(expAck));
      if (validOut && !prevValid) begin
         if (sbQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got unexpected word 0x%0h, required no capture", dataOut);
         end else begin
            compare("scoreboard", int'(dataOut), int'(sbQueue.pop_front()));
         end
      end
      prevValid = validOut;
   endtask

   // Async reset asserted mid-cycle; outputs must clear before any further clock edge.
   task automatic doReset();
      @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      compare("rstValid", int'(validOut), 0);
      compare("rstData", int'(dataOut), 0);
      compare("rstAck", int'(ackOut), 0);
      compare("rstErr", int'(errOut), 0);
      compare("rstCount", int'(countOut), 0);
      compare("rstCountSmall", int'(countOutS), 0);
      @(negedge clock);
      reqLevel = 1'b0;
      reqSync  = 1'b0;
      ready    = 1'b0;
      dataIn   = 8'h00;
      sbQueue.delete();
      prevValid = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      reqSync = 1'b0;
      dataIn  = 8'h00;
      ready   = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Single transfer with ready high, then 0x3C held through 5 stalled cycles while data_i moves.
      vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 16'd0, 1'b0};
      vecs[1] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 16'd1, 1'b0};
      vecs[2] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 16'd1, 1'b0};
      for (int i = 3; i < 8; i++)
         vecs[i] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 16'd1, 1'b0};
      vecs[8] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 16'd2, 1'b0};

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].tog, vecs[i].data, vecs[i].rdy, vecs[i].push);
         checkOutput(vecs[i].expValid, vecs[i].expData, vecs[i].expAck, vecs[i].expCount, vecs[i].expErr);
      end

      // Reset while a word is pending in HOLD discards it.
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
      doReset();

      // Back-to-back transfers, a new request each time ack flips.
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b1, 1'b1);
         checkOutput(1'b1, 8'(i), logic'((i - 1) % 2), 16'(i - 1), 1'b0);
         applyStimulus(1'b0, 8'(i), 1'b1, 1'b0);
         checkOutput(1'b0, 8'(i), logic'(i % 2), 16'(i), 1'b0);
      end

      // Toggle during a stall: flagged, dropped, and only one ack for the held word.
      applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1);
      checkOutput(1'b1, 8'h5A, 1'b0, 16'd4, 1'b0);
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
      checkOutput(1'b1, 8'h5A, 1'b0, 16'd4, 1'b1);
      applyStimulus(1'b0, 8'h77, 1'b0, 1'b0);
      checkOutput(1'b1, 8'h5A, 1'b0, 16'd4, 1'b1);
      applyStimulus(1'b0, 8'h77, 1'b1, 1'b0);
      checkOutput(1'b0, 8'h5A, 1'b1, 16'd5, 1'b1);
      applyStimulus(1'b0, 8'h77, 1'b1, 1'b0);
      checkOutput(1'b0, 8'h5A, 1'b1, 16'd5, 1'b1);

      // Toggle on the accepting edge is also dropped: no capture follows.
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
      checkOutput(1'b1, 8'h11, 1'b1, 16'd5, 1'b1);
      applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
      checkOutput(1'b0, 8'h11, 1'b0, 16'd6, 1'b1);
      applyStimulus(1'b0, 8'h22, 1'b1, 1'b0);
      checkOutput(1'b0, 8'h11, 1'b0, 16'd6, 1'b1);

      // 17 transfers: the 4-bit counter wraps to 1, the 16-bit one reads 17.
      doReset();
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(1'b1, 8'(8'h40 + i), 1'b1, 1'b1);
         checkOutput(1'b1, 8'(8'h40 + i), logic'((i - 1) % 2), 16'(i - 1), 1'b0);
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         checkOutput(1'b0, 8'(8'h40 + i), logic'(i % 2), 16'(i), 1'b0);
      end
      compare("wrapCountSmall", int'(countOutS), 1);
      compare("wrapAckSmall", int'(ackOutS), 1);
      compare("sbDrained", sbQueue.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
